// File: rtl/led_anim_seq.sv
`default_nettype none
// ============================================================================
// Module      : led_anim_seq
// Description : LED animation sequencer. Holds a writable table of active-low
//               segment patterns and steps through frames 0..last at a
//               programmable rate. It supports four modes: loop, one-shot,
//               ping-pong and reverse loop.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               wr_en/wr_addr/wr_data - frame-table write port
//               start, stop, pause  - sequence control (stop beats start)
//               mode, last, div     - latched on start
//               seg                 - registered active-low pattern
//               frame               - current frame index
//               busy                - high while running (also while paused)
//               wrap, done          - single-cycle event pulses
// Revision    : 1.0 - initial release
// ============================================================================
module led_anim_seq #(
    parameter int SEG_W = 7,
    parameter int IDX_W = 5,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [SEG_W-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] last,
    input  logic [DIV_W-1:0] div,
    output logic [SEG_W-1:0] seg,
    output logic [IDX_W-1:0] frame,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam int FRAMES = 2 ** IDX_W;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    localparam logic [1:0] c_mode_loop = 2'd0;
    localparam logic [1:0] c_mode_one  = 2'd1;
    localparam logic [1:0] c_mode_pp   = 2'd2;

    logic [SEG_W-1:0] r_table [0:FRAMES-1];

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [IDX_W-1:0] r_last;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_frame;
    logic             r_down;
    logic [SEG_W-1:0] r_seg;
    logic             r_wrap;
    logic             r_done;

    logic             w_adv;
    logic             w_tick;

    // The frame table has no reset, so its contents survive reset and stop.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    assign w_adv  = (r_state == c_run) && !pause;
    assign w_tick = w_adv && (r_cnt == r_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_mode  <= c_mode_loop;
            r_last  <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_frame <= '0;
            r_down  <= 1'b0;
            r_seg   <= '1;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            // The table is read live from the frame register. A write to the
            // same address in this cycle is not visible until the next read.
            r_seg  <= (r_state == c_idle) ? '1 : r_table[r_frame];

            if (stop) begin
                r_state <= c_idle;
                r_cnt   <= '0;
                r_frame <= '0;
                r_down  <= 1'b0;
                r_seg   <= '1;
            end else if (start) begin
                r_state <= c_run;
                r_mode  <= mode;
                r_last  <= last;
                r_div   <= div;
                r_cnt   <= '0;
                r_frame <= (mode == 2'd3) ? last : '0;
                r_down  <= 1'b0;
            end else if (w_adv) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    case (r_mode)
                        c_mode_loop: begin
                            if (r_frame == r_last) begin
                                r_frame <= '0;
                                r_wrap  <= 1'b1;
                            end else begin
                                r_frame <= r_frame + 1'b1;
                            end
                        end
                        c_mode_one: begin
                            if (r_frame == r_last) begin
                                r_state <= c_hold;
                                r_done  <= 1'b1;
                            end else begin
                                r_frame <= r_frame + 1'b1;
                            end
                        end
                        c_mode_pp: begin
                            if (r_last == '0) begin
                                r_wrap <= 1'b1;
                            end else if (!r_down && (r_frame != r_last)) begin
                                r_frame <= r_frame + 1'b1;
                            end else begin
                                // Descending, or turning around at last.
                                // Reaching frame 0 ends the cycle.
                                r_frame <= r_frame - 1'b1;
                                if (r_frame == {{(IDX_W-1){1'b0}}, 1'b1}) begin
                                    r_down <= 1'b0;
                                    r_wrap <= 1'b1;
                                end else begin
                                    r_down <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            if (r_frame == '0) begin
                                r_frame <= r_last;
                                r_wrap  <= 1'b1;
                            end else begin
                                r_frame <= r_frame - 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign seg   = r_seg;
    assign frame = r_frame;
    assign busy  = (r_state == c_run);
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_anim_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_anim_seq
// Description : Directed bench for led_anim_seq. Inputs are driven 1 ns after
//               each rising edge, and outputs are compared at that same point.
//               Each edge index k counts from the start edge (k = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_anim_seq;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [6:0] wr_data;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] mode;
    logic [4:0] last;
    logic [15:0] div;
    logic [6:0] seg;
    logic [4:0] frame;
    logic       busy;
    logic       wrap;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Table contents used throughout: t0=3F t1=76 t2=24 (after rewrite) t3=3F t4=12
    logic [4:0] e2_frame [14] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0};
    logic [6:0] e2_seg   [14] = '{7'h7F,7'h3F,7'h3F,7'h3F,7'h76,7'h76,7'h76,
                                  7'h7F,7'h7F,7'h7F,7'h3F,7'h3F,7'h3F,7'h3F};
    logic [4:0] e3_frame [6]  = '{0,1,2,2,2,2};
    logic [6:0] e3_seg   [6]  = '{7'h7F,7'h3F,7'h76,7'h24,7'h24,7'h24};
    logic       e3_done  [6]  = '{0,0,0,1,0,0};
    logic       e3_busy  [6]  = '{1,1,1,0,0,0};
    logic [4:0] e4_frame [9]  = '{0,1,2,3,2,1,0,1,2};
    logic [6:0] e4_seg   [9]  = '{7'h7F,7'h3F,7'h76,7'h24,7'h3F,7'h24,7'h76,7'h3F,7'h76};
    logic [4:0] e5_frame [16] = '{4,4,3,3,2,2,2,2,2,2,2,1,1,0,0,4};
    logic [6:0] e5_seg   [16] = '{7'h7F,7'h12,7'h12,7'h3F,7'h3F,7'h24,7'h24,7'h24,
                                  7'h24,7'h24,7'h24,7'h24,7'h76,7'h76,7'h3F,7'h3F};

    led_anim_seq #(.SEG_W(7), .IDX_W(5), .DIV_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .mode    (mode),
        .last    (last),
        .div     (div),
        .seg     (seg),
        .frame   (frame),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [6:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [4:0] l, input logic [15:0] d);
        start = 1'b1; mode = m; last = l; div = d;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; mode = '0; last = '0; div = '0;
        step(); step();
        chk("rst seg",   {25'd0, seg},  32'h7F);
        chk("rst frame", {27'd0, frame}, 32'd0);
        chk("rst busy",  {31'd0, busy}, 32'd0);
        chk("rst wrap",  {31'd0, wrap}, 32'd0);
        chk("rst done",  {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();

        // Loop mode, period 3
        wr(5'd0, 7'h3F); wr(5'd1, 7'h76); wr(5'd2, 7'h7F); wr(5'd3, 7'h3F); wr(5'd4, 7'h12);
        do_start(2'd0, 5'd3, 16'd2);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step();
            chk($sformatf("loop frame[%0d]", k), {27'd0, frame}, {27'd0, e2_frame[k]});
            chk($sformatf("loop seg[%0d]", k),   {25'd0, seg},   {25'd0, e2_seg[k]});
            chk($sformatf("loop wrap[%0d]", k),  {31'd0, wrap},  (k == 12) ? 32'd1 : 32'd0);
            chk($sformatf("loop busy[%0d]", k),  {31'd0, busy},  32'd1);
        end
        do_stop();
        chk("stop busy", {31'd0, busy}, 32'd0);
        chk("stop seg",  {25'd0, seg},  32'h7F);

        // One-shot
        wr(5'd2, 7'h24);
        do_start(2'd1, 5'd2, 16'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            chk($sformatf("one frame[%0d]", k), {27'd0, frame}, {27'd0, e3_frame[k]});
            chk($sformatf("one seg[%0d]", k),   {25'd0, seg},   {25'd0, e3_seg[k]});
            chk($sformatf("one done[%0d]", k),  {31'd0, done},  {31'd0, e3_done[k]});
            chk($sformatf("one busy[%0d]", k),  {31'd0, busy},  {31'd0, e3_busy[k]});
        end
        do_stop();
        chk("hold stop seg", {25'd0, seg}, 32'h7F);

        // Ping-pong
        do_start(2'd2, 5'd3, 16'd0);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            chk($sformatf("pp frame[%0d]", k), {27'd0, frame}, {27'd0, e4_frame[k]});
            chk($sformatf("pp seg[%0d]", k),   {25'd0, seg},   {25'd0, e4_seg[k]});
            chk($sformatf("pp wrap[%0d]", k),  {31'd0, wrap},  (k == 6) ? 32'd1 : 32'd0);
        end
        // Restart while running: ping-pong with last=0
        do_start(2'd2, 5'd0, 16'd0);
        chk("pp0 wrap[0]", {31'd0, wrap}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("pp0 frame[%0d]", k), {27'd0, frame}, 32'd0);
            chk($sformatf("pp0 wrap[%0d]", k),  {31'd0, wrap},  32'd1);
        end
        do_stop();

        // Reverse loop with a 5-cycle pause after edge 4
        do_start(2'd3, 5'd4, 16'd1);
        chk("rev frame[0]", {27'd0, frame}, {27'd0, e5_frame[0]});
        for (int k = 1; k < 16; k++) begin
            pause = (k >= 5 && k <= 9);
            step();
            chk($sformatf("rev frame[%0d]", k), {27'd0, frame}, {27'd0, e5_frame[k]});
            chk($sformatf("rev seg[%0d]", k),   {25'd0, seg},   {25'd0, e5_seg[k]});
            chk($sformatf("rev wrap[%0d]", k),  {31'd0, wrap},  (k == 15) ? 32'd1 : 32'd0);
            chk($sformatf("rev busy[%0d]", k),  {31'd0, busy},  32'd1);
        end
        pause = 1'b0;

        // Live write to the displayed frame, mid-frame
        do_start(2'd0, 5'd3, 16'd7);
        wr(5'd0, 7'h00);
        chk("live seg old", {25'd0, seg}, 32'h3F);
        step();
        chk("live seg new", {25'd0, seg},   32'h00);
        chk("live frame",   {27'd0, frame}, 32'd0);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; mode = 2'd0; last = 5'd3; div = 16'd0;
        step();
        start = 1'b0; stop = 1'b0;
        chk("prio busy", {31'd0, busy}, 32'd0);
        chk("prio seg",  {25'd0, seg},  32'h7F);
        step();
        chk("prio seg idle", {25'd0, seg}, 32'h7F);

        // Asynchronous reset mid-run, then table readback
        do_start(2'd0, 5'd3, 16'd0);
        step(); step();
        chk("pre-rst frame", {27'd0, frame}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst seg",   {25'd0, seg},   32'h7F);
        chk("arst frame", {27'd0, frame}, 32'd0);
        chk("arst busy",  {31'd0, busy},  32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_start(2'd1, 5'd1, 16'd0);
        step();
        chk("keep t0", {25'd0, seg}, 32'h00);
        step();
        chk("keep t1",   {25'd0, seg},  32'h76);
        chk("keep done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
